pool_frame_collector: RTL and testbench

- Upstream neighbour of the max-pooling stage.
- Accepts a raster-order stream of 32-bit feature-map words over a valid/ready handshake and assembles one complete input_size x input_size frame into a packed array.
- Presents the frame to the pooling stage with a frame-level valid/ready handshake.
- Holds the frame stable until the pooling stage accepts it; flags framing errors.

---
 rtl/pool_frame_collector.sv | 172 +++++++++++++++++
 tb/tb_pool_frame_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_frame_collector.sv
// pool_frame_collector
// Collects a raster-order stream of 32-bit feature-map words into one
// input_size x input_size frame and offers it to the max-pooling stage with
// a frame-level valid/ready handshake. A frame is held stable until the
// pooling stage accepts it. Framing errors (in_last early or missing) set a
// sticky flag.
//
// Build option: define POOL_FRAME_PINGPONG_EN for two frame banks, so the
// next frame fills while the previous one is presented. Without it a single
// bank is used and the stream is stalled for as long as a frame is held.
module pool_frame_collector #(
  parameter int input_size = 8,
  parameter int CNT_W      = $clog2(input_size*input_size+1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [31:0]                            in_data,
  input  logic                                   in_last,
  output logic [input_size*input_size-1:0][31:0] frame_data,
  output logic                                   frame_valid,
  input  logic                                   frame_ready,
  output logic [CNT_W-1:0]                       fill_count,
  output logic                                   frame_err,
  input  logic                                   err_clr
);

  localparam int NW = input_size*input_size;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NW-1);

  // FILL: no frame presented. HOLD: a frame is presented.
  // FULL: (ping-pong only) a frame is presented and the other bank is also
  // complete, so the stream must stall until the presented one is taken.
  typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1, FULL = 2'd2} state_t;

  state_t state;
  state_t state_nxt;
  logic   in_ready_nxt;
  logic   transfer;
  logic   at_last;
  logic   complete;
  logic   short_frame;
  logic   long_frame;
  logic   accept;
`ifdef POOL_FRAME_PINGPONG_EN
  logic   present_new;
`endif

  assign transfer    = in_valid && in_ready;
  assign at_last     = (fill_count == LAST_IDX);
  assign complete    = transfer && at_last;
  assign short_frame = transfer && !at_last && in_last;
  assign long_frame  = complete && !in_last;
  assign accept      = frame_valid && frame_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state logic: completion of the fill frame and acceptance by the
  // pooling stage are the only events that move the FSM
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (complete) state_nxt = HOLD;
`ifdef POOL_FRAME_PINGPONG_EN
      HOLD: begin
        if (accept && !complete)      state_nxt = FILL;
        else if (!accept && complete) state_nxt = FULL;
      end
      FULL: if (accept) state_nxt = HOLD;
`else
      HOLD: if (accept) state_nxt = FILL;
`endif
      default: state_nxt = FILL;
    endcase
  end

  // Output decode; in_ready is computed from the next state and registered
  // below so frame_ready never reaches it combinationally
  always_comb begin
    frame_valid = (state != FILL);
`ifdef POOL_FRAME_PINGPONG_EN
    in_ready_nxt = (state_nxt != FULL);
    // A freshly completed bank becomes the presented one when nothing is
    // presented, or when the presented bank is being accepted this cycle
    present_new  = (complete && (state == FILL || accept)) ||
                   (state == FULL && accept);
`else
    in_ready_nxt = (state_nxt == FILL);
`endif
  end

  // Registered in_ready; low during reset, rises on the first clock after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= in_ready_nxt;
  end

  // Word counter: restarts after the final word or after an early in_last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
    end else if (transfer) begin
      if (at_last || in_last) fill_count <= '0;
      else                    fill_count <= fill_count + CNT_W'(1);
    end
  end

  // Sticky framing-error flag; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          frame_err <= 1'b0;
    else if (short_frame || long_frame)  frame_err <= 1'b1;
    else if (err_clr)                    frame_err <= 1'b0;
  end

`ifdef POOL_FRAME_PINGPONG_EN
  logic [NW-1:0][31:0] bank0;
  logic [NW-1:0][31:0] bank1;
  logic                fill_sel;
  logic                pres_sel;

  // Bank pointers: the completed fill bank becomes presented, filling moves
  // to the other bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sel <= 1'b0;
      pres_sel <= 1'b0;
    end else if (present_new) begin
      pres_sel <= fill_sel;
      fill_sel <= ~fill_sel;
    end
  end

  // Bank storage: each accepted word lands in the fill bank at fill_count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (transfer) begin
      for (int i = 0; i < NW; i++) begin
        if (fill_count == CNT_W'(i)) begin
          if (fill_sel) bank1[i] <= in_data;
          else          bank0[i] <= in_data;
        end
      end
    end
  end

  assign frame_data = pres_sel ? bank1 : bank0;
`else
  logic [NW-1:0][31:0] frame_mem;

  // Frame storage: each accepted word lands at fill_count; no transfers
  // occur while a frame is held, so the presented data stays frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_mem <= '0;
    end else if (transfer) begin
      for (int i = 0; i < NW; i++) begin
        if (fill_count == CNT_W'(i)) frame_mem[i] <= in_data;
      end
    end
  end

  assign frame_data = frame_mem;
`endif

endmodule

// File: tb/tb_pool_frame_collector.sv
// Self-checking bench for pool_frame_collector with input_size = 4.
module tb_pool_frame_collector;

  localparam int N  = 4;
  localparam int NW = N*N;
  localparam int CW = $clog2(NW+1);
`ifdef POOL_FRAME_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_data;
  logic                 in_last;
  logic [NW-1:0][31:0]  frame_data;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [CW-1:0]        fill_count;
  logic                 frame_err;
  logic                 err_clr;

  pool_frame_collector #(.input_size(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .fill_count (fill_count),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_frame [NW];
  logic [31:0] rwords    [NW];

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        clr;
    int          fill;
    logic        valid;
    logic        err;
  } rec_t;

  rec_t tbl[$];
  logic [31:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] d, input logic l, input logic c,
                              input int f, input logic v, input logic e);
    rec_t r;
    r.data = d; r.last = l; r.clr = c; r.fill = f; r.valid = v; r.err = e;
    tbl.push_back(r);
  endfunction

  // Present one word at a negedge; return at the negedge after it transferred
  task automatic send_word(input logic [31:0] d, input logic l, input logic clr,
                           input logic noise);
    int w = 0;
    in_valid    = 1'b1;
    in_data     = d;
    in_last     = l;
    err_clr     = clr;
    frame_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid    = 1'b0;
    in_last     = 1'b0;
    err_clr     = 1'b0;
    frame_ready = 1'b0;
  endtask

  // Check a held frame against exp_frame, then accept it for one cycle
  task automatic accept_frame(input string nm);
    chk({nm, "_valid"}, {31'd0, frame_valid}, 32'd1);
    chk({nm, "_in_ready_held"}, {31'd0, in_ready}, {31'd0, PP});
    for (int k = 0; k < NW; k++)
      chk($sformatf("%s_data[%0d]", nm, k), frame_data[k], exp_frame[k]);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk({nm, "_valid_after_accept"}, {31'd0, frame_valid}, 32'd0);
    chk({nm, "_in_ready_after_accept"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int len;
    logic model_err;
    logic lst;

    // Table: good frame 1..16, good frame 101..116, short frame (last on
    // word 7), good frame with sticky error, unterminated frame with a clear
    // on its first word, short frame whose error coincides with err_clr
    for (int i = 1; i <= NW; i++) add(i, i == NW, 1'b0, i % NW, i == NW, 1'b0);
    for (int i = 1; i <= NW; i++) add(100 + i, i == NW, 1'b0, i % NW, i == NW, 1'b0);
    for (int i = 1; i <= 7; i++)  add(i, i == 7, 1'b0, (i == 7) ? 0 : i, 1'b0, i == 7);
    for (int i = 1; i <= NW; i++) add(i, i == NW, 1'b0, i % NW, i == NW, 1'b1);
    for (int i = 1; i <= NW; i++) add(200 + i, 1'b0, i == 1, i % NW, i == NW, i == NW);
    add(301, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    add(302, 1'b1, 1'b1, 0, 1'b0, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    frame_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fill_count", {27'd0, fill_count}, 32'd0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_frame_data0", frame_data[0], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // Table-driven streaming
    for (int r = 0; r < tbl.size(); r++) begin
      send_word(tbl[r].data, tbl[r].last, tbl[r].clr, 1'b0);
      q.push_back(tbl[r].data);
      chk($sformatf("tbl%0d_fill_count", r), {27'd0, fill_count}, tbl[r].fill);
      chk($sformatf("tbl%0d_frame_valid", r), {31'd0, frame_valid}, {31'd0, tbl[r].valid});
      chk($sformatf("tbl%0d_frame_err", r), {31'd0, frame_err}, {31'd0, tbl[r].err});
      if (tbl[r].valid) begin
        for (int k = 0; k < NW; k++) exp_frame[k] = q[k];
        q.delete();
        repeat (2) @(negedge clk);
        chk($sformatf("tbl%0d_hold_fill_count", r), {27'd0, fill_count}, 32'd0);
        accept_frame($sformatf("tbl%0d", r));
      end else if (tbl[r].fill == 0) begin
        q.delete();
      end
    end

    // Reset in the middle of a frame, with the error flag still set
    for (int i = 1; i <= 9; i++) send_word(i, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_fill_count", {27'd0, fill_count}, 32'd9);
    chk("pre_rst_frame_err", {31'd0, frame_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fill_count", {27'd0, fill_count}, 32'd0);
    chk("mid_rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_frame_data8", frame_data[8], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 1; i <= NW; i++) send_word(i, i == NW, 1'b0, 1'b0);
    for (int k = 0; k < NW; k++) exp_frame[k] = k + 1;
    accept_frame("post_rst");

    // Short frame, then a standalone err_clr
    for (int i = 1; i <= 3; i++) send_word(50 + i, i == 3, 1'b0, 1'b0);
    chk("short3_err", {31'd0, frame_err}, 32'd1);
    chk("short3_fill", {27'd0, fill_count}, 32'd0);
    chk("short3_valid", {31'd0, frame_valid}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, frame_err}, 32'd0);

    // Randomised frames checked against a frame-level model
    model_err = 1'b0;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = 1'b0;
        chk($sformatf("rnd%0d_clr", f), {31'd0, frame_err}, 32'd0);
      end
      kind = $urandom_range(0, 5);           // 0 short, 1 unterminated, else good
      len  = (kind == 0) ? $urandom_range(1, NW - 1) : NW;
      for (int i = 0; i < len; i++) rwords[i] = $urandom;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        if (kind != 0 && i == NW - 1)
          chk($sformatf("rnd%0d_fill_before_last", f), {27'd0, fill_count}, NW - 1);
        if (kind == 0)      lst = (i == len - 1);
        else if (kind == 1) lst = 1'b0;
        else                lst = (i == NW - 1);
        send_word(rwords[i], lst, 1'b0, 1'b1);
      end
      if (kind < 2) model_err = 1'b1;
      chk($sformatf("rnd%0d_err", f), {31'd0, frame_err}, {31'd0, model_err});
      chk($sformatf("rnd%0d_fill", f), {27'd0, fill_count}, 32'd0);
      chk($sformatf("rnd%0d_valid", f), {31'd0, frame_valid}, {31'd0, kind != 0});
      if (kind != 0) begin
        for (int k = 0; k < NW; k++) exp_frame[k] = rwords[k];
        repeat ($urandom_range(0, 3)) @(negedge clk);
        accept_frame($sformatf("rnd%0d", f));
      end
    end

`ifdef POOL_FRAME_PINGPONG_EN
    // Two frames streamed back to back with the consumer stalled
    for (int i = 1; i <= NW; i++) send_word(i, i == NW, 1'b0, 1'b0);
    chk("pp_first_valid", {31'd0, frame_valid}, 32'd1);
    for (int i = 1; i <= NW; i++) begin
      chk($sformatf("pp_in_ready_w%0d", i), {31'd0, in_ready}, 32'd1);
      send_word(100 + i, i == NW, 1'b0, 1'b0);
    end
    chk("pp_in_ready_full", {31'd0, in_ready}, 32'd0);
    repeat (20) @(negedge clk);
    chk("pp_stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("pp_held_data0", frame_data[0], 32'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("pp_swap_valid", {31'd0, frame_valid}, 32'd1);
    chk("pp_swap_data0", frame_data[0], 32'd101);
    chk("pp_swap_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < NW; k++) exp_frame[k] = 101 + k;
    accept_frame("pp_second");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
